async_fifo_write_arbiter: RTL

Shares the single write port of async_fifo among NUM_REQ requesters in the write clock domain.
- Round-robin arbitration; the grant is held for a burst of up to MAX_BURST beats.
- Per-requester valid/ready handshake; the FIFO full flag is honoured so no write is ever issued while full.
- Sits directly in front of async_fifo's p_write_en/p_write_data/p_write_full, clocked by the same clock as the FIFO write side.

---
 rtl/async_fifo_write_arbiter_pkg.sv | 30 +++
 rtl/async_fifo_write_arbiter_if.sv | 15 +
 rtl/async_fifo_write_arbiter_rr_picker.sv | 23 ++
 rtl/async_fifo_write_arbiter.sv | 123 ++++++++++++
 4 files changed

// File: rtl/async_fifo_write_arbiter_pkg.sv
// Shared types and helpers for the async FIFO write-port arbiter.
//   arb_state_t : arbiter FSM states
//   STALL_W     : width of the saturating stall counter
//   rr_next()   : round-robin pick, first set bit of mask after 'last'
package async_fifo_write_arbiter_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  localparam int unsigned STALL_W = 16;
  localparam int unsigned MAX_REQ = 8;
  localparam int unsigned IDX_W   = 3;

  // Scan downward so the closest candidate after 'last' is written last and wins.
  function automatic logic [IDX_W-1:0] rr_next(input logic [MAX_REQ-1:0] mask,
                                               input logic [IDX_W-1:0]   last,
                                               input int                 n);
    logic [IDX_W-1:0] idx;
    rr_next = last;
    for (int k = int'(MAX_REQ); k >= 1; k--) begin
      if (k <= n) begin
        idx = IDX_W'((int'(last) + k) % n);
        if (mask[idx]) rr_next = idx;
      end
    end
  endfunction

endpackage

// File: rtl/async_fifo_write_arbiter_if.sv
// Requester-side bus of the write arbiter: per-requester valid/last/data/ready.
//   master : requester view (drives valid/last/data, receives ready)
//   slave  : arbiter view
interface async_fifo_write_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned BITS    = 32
);
  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ-1:0]      req_last;
  logic [NUM_REQ*BITS-1:0] req_data;
  logic [NUM_REQ-1:0]      req_ready;

  modport master (output req_valid, output req_last, output req_data, input req_ready);
  modport slave  (input req_valid, input req_last, input req_data, output req_ready);
endinterface

// File: rtl/async_fifo_write_arbiter_rr_picker.sv
// Combinational round-robin priority picker.
//   mask  : candidate requesters
//   last  : index that had priority last; search starts at last+1
//   found : any candidate present
//   index : chosen requester (valid only when found)
module async_fifo_write_arbiter_rr_picker
  import async_fifo_write_arbiter_pkg::*;
#(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] mask,
  input  logic [ID_W-1:0]    last,
  output logic               found,
  output logic [ID_W-1:0]    index
);

  always_comb begin
    found = |mask;
    index = ID_W'(rr_next(MAX_REQ'(mask), IDX_W'(last), int'(NUM_REQ)));
  end

endmodule

// File: rtl/async_fifo_write_arbiter.sv
// Shares async_fifo's single write port among NUM_REQ requesters with
// round-robin grants held for bursts of up to MAX_BURST beats.
//   write_clk, write_rst_n : write-domain clock, async active-low reset
//   req                    : requester valid/last/data/ready bus
//   p_write_en/data/full   : async_fifo write port
//   grant_valid, grant_id  : current grant holder
//   stall_count            : saturating cycles granted-but-blocked by full
module async_fifo_write_arbiter
  import async_fifo_write_arbiter_pkg::*;
#(
  parameter  int unsigned BITS      = 32,
  parameter  int unsigned NUM_REQ   = 4,
  parameter  int unsigned MAX_BURST = 4,
  localparam int unsigned ID_W      = $clog2(NUM_REQ)
) (
  input  logic                       write_clk,
  input  logic                       write_rst_n,
  async_fifo_write_arbiter_if.slave  req,
  output logic                       p_write_en,
  output logic [BITS-1:0]            p_write_data,
  input  logic                       p_write_full,
  output logic                       grant_valid,
  output logic [ID_W-1:0]            grant_id,
  output logic [STALL_W-1:0]         stall_count
);

  localparam int unsigned       BCNT_W    = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [BCNT_W-1:0] BEAT_LAST = BCNT_W'(MAX_BURST - 1);

  arb_state_t          state, state_n;
  logic [ID_W-1:0]     grant_n;
  logic [ID_W-1:0]     last_grant, last_grant_n;
  logic [BCNT_W-1:0]   beat_cnt, beat_cnt_n;
  logic                stall_inc;

  logic [NUM_REQ-1:0]  pick_mask;
  logic [ID_W-1:0]     pick_last;
  logic                pick_found;
  logic [ID_W-1:0]     pick_idx;

  logic                g_valid;
  logic                g_last;
  logic                accept;
  logic                rel;

  // Picker inputs: fresh arbitration in IDLE, handoff excluding the holder in GRANT.
  always_comb begin
    pick_mask = req.req_valid;
    pick_last = last_grant;
    if (state == GRANT) begin
      pick_mask = req.req_valid & ~(NUM_REQ'(1) << grant_id);
      pick_last = grant_id;
    end
  end

  async_fifo_write_arbiter_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .mask  (pick_mask),
    .last  (pick_last),
    .found (pick_found),
    .index (pick_idx)
  );

  // State and counters.
  always_ff @(posedge write_clk or negedge write_rst_n) begin
    if (!write_rst_n) begin
      state       <= IDLE;
      grant_id    <= '0;
      last_grant  <= ID_W'(NUM_REQ - 1);
      beat_cnt    <= '0;
      stall_count <= '0;
    end else begin
      state      <= state_n;
      grant_id   <= grant_n;
      last_grant <= last_grant_n;
      beat_cnt   <= beat_cnt_n;
      if (stall_inc) stall_count <= stall_count + STALL_W'(1);
    end
  end

  // Next state, handshake and FIFO write strobe.
  always_comb begin
    state_n      = state;
    grant_n      = grant_id;
    last_grant_n = last_grant;
    beat_cnt_n   = beat_cnt;
    req.req_ready = '0;
    p_write_en   = 1'b0;
    accept       = 1'b0;
    rel          = 1'b0;
    stall_inc    = 1'b0;
    g_valid      = req.req_valid[grant_id];
    g_last       = req.req_last[grant_id];
    p_write_data = req.req_data[grant_id*BITS +: BITS];

    case (state)
      IDLE: begin
        if (pick_found) begin
          grant_n = pick_idx;
          state_n = GRANT;
        end
      end
      GRANT: begin
        req.req_ready[grant_id] = ~p_write_full;
        accept     = g_valid & ~p_write_full;
        p_write_en = accept;
        stall_inc  = g_valid & p_write_full & (stall_count != '1);
        if (accept) beat_cnt_n = beat_cnt + BCNT_W'(1);
        // Full freezes the grant; otherwise release on last, burst limit or a dropped valid.
        rel = ~p_write_full & ((accept & (g_last | (beat_cnt == BEAT_LAST))) | ~g_valid);
        if (rel) begin
          last_grant_n = grant_id;
          beat_cnt_n   = '0;
          if (pick_found) grant_n = pick_idx;
          else            state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign grant_valid = (state == GRANT);

endmodule
